// File: rtl/uart_rx_byte_if.sv
// Receiver-side signal bundle: serial line in, recovered byte and status strobes out.
`timescale 1ns/1ps
interface uart_rx_byte_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    // Receiver: consumes the line, produces byte/status.
    modport master (
        input  rx,
        output rx_data,
        output rx_done,
        output frame_err,
        output rx_busy
    );

    // Line driver / downstream consumer.
    modport slave (
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first. Emits a one-cycle rx_done per good byte and a
// one-cycle frame_err when the stop bit is low; a low line after a bad stop is
// held off in StBrk so a break cannot retrigger reception.
`timescale 1ns/1ps
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic           clk,
    input  logic           n_reset,
    uart_rx_byte_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitEnd   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd  = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBrk} state_e;

    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]      fill_q;
    logic            fall;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done_pend_q, done_pend_d;
    logic            err_pend_q, err_pend_d;
    logic [7:0]      rx_data_q;
    logic            rx_done_q, frame_err_q;

    // Two-flop synchronizer plus one history flop; fill_q marks which stages hold real samples.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= 3'b000;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            fill_q    <= {fill_q[1:0], 1'b1};
        end
    end

    // Edges are only trusted once the reset-preset ones have been flushed out of the chain,
    // so a line held low across reset is not mistaken for a start bit.
    assign fall = fill_q[2] & rx_prev_q & ~rx_s_q;

    // Receive state, baud counter, bit index, shift register and strobe requests.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            done_pend_q <= done_pend_d;
            err_pend_q  <= err_pend_d;
        end
    end

    // Next-state: sample mid-start, then once per bit period at the bit centres.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        done_pend_d = 1'b0;
        err_pend_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitEnd) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        done_pend_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        err_pend_d = 1'b1;
                        state_d    = StBrk;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBrk: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: data and strobes land together one cycle after the stop sample.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q   <= done_pend_q;
            frame_err_q <= err_pend_q;
            if (done_pend_q) begin
                rx_data_q <= shift_q;
            end
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomized bench for uart_rx_byte at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_byte;
    localparam int ClkNs  = 10;
    localparam int Cpb    = 10;
    localparam int Half   = Cpb / 2;
    localparam int BitNs  = Cpb * ClkNs;
    localparam int LatMin = (Half + 9 * Cpb + 3) * ClkNs;
    localparam int LatMax = (Half + 9 * Cpb + 4) * ClkNs;

    logic clk;
    logic n_reset;
    uart_rx_byte_if bus ();

    uart_rx_byte #(
        .CLK_FREQ(1000000),
        .BAUD    (100000)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #(ClkNs / 2) clk = ~clk;

    int   n_err;
    int   n_chk;
    logic [7:0] got_data[$];
    time        got_time[$];
    int   err_seen;
    int   both_cnt;
    int   wide_cnt;
    int   chg_bad;
    bit   busy_seen;
    bit   done_last;
    bit   err_last;
    logic [7:0] prev_data;
    time  fall_t;

    // Observer: logs strobes and flags protocol violations away from the active edge.
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_data = 8'h00;
            done_last = 1'b0;
            err_last  = 1'b0;
        end else begin
            if (bus.rx_done) begin
                got_data.push_back(bus.rx_data);
                got_time.push_back($time);
            end else if (bus.rx_data !== prev_data) begin
                chg_bad++;
            end
            prev_data = bus.rx_data;
            if (bus.frame_err) err_seen++;
            if (bus.rx_done && bus.frame_err) both_cnt++;
            if ((bus.rx_done && done_last) || (bus.frame_err && err_last)) wide_cnt++;
            done_last = bus.rx_done;
            err_last  = bus.frame_err;
            if (bus.rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got_data.delete();
        got_time.delete();
        err_seen  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Drive one 8N1 frame; stop_val = 0 makes a framing error and leaves the line low.
    task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_val);
        bus.rx = 1'b0;
        fall_t = $time;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        bus.rx = stop_val;
        #(bit_ns);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.rx_busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, bus.rx_busy}, 32'd0);
    endtask

    // Failsafe so the run always ends.
    initial begin
        #500us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] frame[4];
        logic [7:0] last_good;
        logic [7:0] b;
        int         exp_err;
        bit         bad;
        int         gap;
        longint     lat;

        n_err = 0; n_chk = 0; chg_bad = 0; both_cnt = 0; wide_cnt = 0;
        n_reset = 1'b0;
        bus.rx  = 1'b1;
        clear_log();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("reset_rx_done", {31'd0, bus.rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        align();
        n_reset = 1'b1;
        repeat (5) @(posedge clk);

        // Single byte with latency window
        align();
        clear_log();
        send_byte(8'hAA, BitNs, 1'b1);
        wait_idle("single_idle");
        repeat (20) @(posedge clk);
        check("single_count", got_data.size(), 32'd1);
        if (got_data.size() > 0) begin
            check("single_data", {24'd0, got_data[0]}, 32'hAA);
            lat = longint'(got_time[0]) - (ClkNs / 2) - longint'(fall_t);
            if (!(lat >= LatMin && lat <= LatMax))
                $display("single latency %0d ns, window %0d..%0d", lat, LatMin, LatMax);
            check("single_latency", {31'd0, (lat >= LatMin && lat <= LatMax)}, 32'd1);
        end
        check("single_frame_err", err_seen, 32'd0);

        // Back-to-back command frame
        frame[0] = 8'hAA; frame[1] = 8'hA5; frame[2] = 8'h05; frame[3] = 8'hFF;
        align();
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(frame[i], BitNs, 1'b1);
        repeat (30) @(posedge clk);
        check("b2b_count", got_data.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_data.size())
                check($sformatf("b2b_data%0d", i), {24'd0, got_data[i]}, {24'd0, frame[i]});

        // Glitch shorter than half a bit
        align();
        clear_log();
        bus.rx = 1'b0;
        #(3 * ClkNs);
        bus.rx = 1'b1;
        repeat (30) @(posedge clk);
        check("glitch_no_done", got_data.size(), 32'd0);
        check("glitch_no_err", err_seen, 32'd0);
        check("glitch_busy_pulse", {31'd0, busy_seen}, 32'd1);
        check("glitch_idle", {31'd0, bus.rx_busy}, 32'd0);

        // Framing error followed by break, then recovery
        align();
        clear_log();
        send_byte(8'h3C, BitNs, 1'b0);
        #(30 * ClkNs);
        bus.rx = 1'b1;
        wait_idle("ferr_idle");
        repeat (10) @(posedge clk);
        check("ferr_pulses", err_seen, 32'd1);
        check("ferr_no_done", got_data.size(), 32'd0);
        check("ferr_data_held", {24'd0, bus.rx_data}, 32'hFF);
        align();
        send_byte(8'h11, BitNs, 1'b1);
        repeat (20) @(posedge clk);
        check("ferr_next_count", got_data.size(), 32'd1);
        if (got_data.size() > 0) check("ferr_next_data", {24'd0, got_data[0]}, 32'h11);
        check("ferr_next_no_err", err_seen, 32'd1);

        // Reset during data bit 4
        align();
        clear_log();
        fork
            send_byte(8'hF0, BitNs, 1'b1);
            begin
                #(5 * BitNs + BitNs / 2);
                n_reset = 1'b0;
                #1;
                check("mreset_rx_data", {24'd0, bus.rx_data}, 32'h00);
                check("mreset_rx_done", {31'd0, bus.rx_done}, 32'd0);
                check("mreset_frame_err", {31'd0, bus.frame_err}, 32'd0);
                check("mreset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
            end
        join
        align();
        n_reset = 1'b1;
        repeat (5) @(posedge clk);
        align();
        clear_log();
        send_byte(8'h5A, BitNs, 1'b1);
        repeat (20) @(posedge clk);
        check("mreset_next_count", got_data.size(), 32'd1);
        if (got_data.size() > 0) check("mreset_next_data", {24'd0, got_data[0]}, 32'h5A);

        // Baud tolerance: 4% slow, then 4% fast
        align();
        clear_log();
        send_byte(8'h96, BitNs + BitNs * 4 / 100, 1'b1);
        repeat (20) @(posedge clk);
        check("slow_count", got_data.size(), 32'd1);
        if (got_data.size() > 0) check("slow_data", {24'd0, got_data[0]}, 32'h96);
        align();
        clear_log();
        send_byte(8'h96, BitNs - BitNs * 4 / 100, 1'b1);
        repeat (20) @(posedge clk);
        check("fast_count", got_data.size(), 32'd1);
        if (got_data.size() > 0) check("fast_data", {24'd0, got_data[0]}, 32'h96);
        check("tol_no_err", err_seen, 32'd0);

        // Randomized frames against a byte-list model
        last_good = 8'h96;
        exp_err   = 0;
        align();
        clear_log();
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_byte(b, BitNs, !bad);
            if (bad) begin
                exp_err++;
                #($urandom_range(5, 30) * ClkNs);
                bus.rx = 1'b1;
                #($urandom_range(5, 20) * ClkNs);
            end else begin
                exp_q.push_back(b);
                last_good = b;
                gap = $urandom_range(0, 3);
                if (gap != 0) #(gap * 4 * ClkNs);
            end
        end
        repeat (30) @(posedge clk);
        check("rand_count", got_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_data.size())
                check($sformatf("rand_data%0d", i), {24'd0, got_data[i]}, {24'd0, exp_q[i]});
        check("rand_errs", err_seen, exp_err);
        check("rand_last_data", {24'd0, bus.rx_data}, {24'd0, last_good});

        // Whole-run protocol properties
        check("never_both", both_cnt, 32'd0);
        check("pulse_width", wide_cnt, 32'd0);
        check("data_only_on_done", chg_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
